// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam int DEF_MULDIV_LAT  = 32;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W       = 16;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ctrl_mux;
    logic ifid_flush;
    logic freeze;
  } ctrl_t;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/memory/muldiv event inputs and pipeline control outputs of the controller.
interface pipe_stall_ctrl_if #(parameter int CNT_W = pipe_ctrl_pkg::DEF_CNT_W);
  logic             HazardReq;
  logic             MulDivStart;
  logic             IDUsesHiLo;
  logic             BranchTaken;
  logic             MemReq;
  logic             MemReady;
  logic             PCStall;
  logic             IFIDStall;
  logic             ControlMux;
  logic             IFIDFlush;
  logic             PipeFreeze;
  logic             MulDivBusy;
  logic             MemError;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output HazardReq, MulDivStart, IDUsesHiLo, BranchTaken, MemReq, MemReady,
    input  PCStall, IFIDStall, ControlMux, IFIDFlush, PipeFreeze,
           MulDivBusy, MemError, StallCycles, FlushCount
  );

  modport slave (
    input  HazardReq, MulDivStart, IDUsesHiLo, BranchTaken, MemReq, MemReady,
    output PCStall, IFIDStall, ControlMux, IFIDFlush, PipeFreeze,
           MulDivBusy, MemError, StallCycles, FlushCount
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (clr)                  r_cnt <= '0;
    else if (inc && ~&r_cnt)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: memory-wait FSM, mul/div busy window,
// priority merge of freeze > front stall > flush, and perf counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT  = DEF_MULDIV_LAT,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic               Clk,
  input logic               Rst,
  pipe_stall_ctrl_if.slave  bus
);
  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

  state_t          r_state, w_next;
  logic [MD_W-1:0] r_md;
  logic [WT_W-1:0] r_wait;
  logic [WT_W-1:0] w_wait_inc;
  logic            w_freeze, w_front, w_md_busy;
  ctrl_t           w_ctrl;

  assign w_md_busy  = (r_md != '0);
  assign w_wait_inc = r_wait + 1'b1;
  assign w_freeze   = (bus.MemReq && !bus.MemReady) || (r_state == FAULT);
  assign w_front    = !w_freeze && (bus.HazardReq || (w_md_busy && bus.IDUsesHiLo));

  always_comb begin
    w_ctrl            = '0;
    w_ctrl.freeze     = w_freeze;
    w_ctrl.pc_stall   = w_freeze || w_front;
    w_ctrl.ifid_stall = w_freeze || w_front;
    w_ctrl.ctrl_mux   = w_front;
    w_ctrl.ifid_flush = bus.BranchTaken && !w_freeze && !w_front;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:      if (bus.MemReq && !bus.MemReady) w_next = MEM_WAIT;
      MEM_WAIT: begin
        if (bus.MemReady)                          w_next = RUN;
        else if (w_wait_inc == WT_W'(MEM_TIMEOUT)) w_next = FAULT;
      end
      FAULT:    w_next = FAULT;
      default:  w_next = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  // Wait count is held at zero in RUN, so it starts from zero on every entry.
  always_ff @(posedge Clk) begin
    if (Rst)                        r_wait <= '0;
    else if (r_state == RUN)        r_wait <= '0;
    else if (r_state == MEM_WAIT)   r_wait <= w_wait_inc;
  end

  // Starts are only accepted when the EX instruction actually advances.
  always_ff @(posedge Clk) begin
    if (Rst)                               r_md <= '0;
    else if (bus.MulDivStart && !w_freeze) r_md <= MD_W'(MULDIV_LAT);
    else if (w_md_busy)                    r_md <= r_md - 1'b1;
  end

  assign bus.PCStall    = w_ctrl.pc_stall;
  assign bus.IFIDStall  = w_ctrl.ifid_stall;
  assign bus.ControlMux = w_ctrl.ctrl_mux;
  assign bus.IFIDFlush  = w_ctrl.ifid_flush;
  assign bus.PipeFreeze = w_ctrl.freeze;
  assign bus.MulDivBusy = w_md_busy;
  assign bus.MemError   = (r_state == FAULT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .clr   (Rst),
    .inc   (w_ctrl.pc_stall),
    .o_cnt (bus.StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .clr   (Rst),
    .inc   (w_ctrl.ifid_flush),
    .o_cnt (bus.FlushCount)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_stall_ctrl;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  pipe_stall_ctrl_if #(.CNT_W(16)) bus();

  pipe_stall_ctrl #(.MULDIV_LAT(4), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // in  = {HazardReq, MulDivStart, IDUsesHiLo, BranchTaken, MemReq, MemReady}
  // exp = {PCStall, IFIDStall, ControlMux, IFIDFlush, PipeFreeze, MulDivBusy}
  typedef struct {
    logic [5:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [5:0] v);
    bus.HazardReq   = v[5];
    bus.MulDivStart = v[4];
    bus.IDUsesHiLo  = v[3];
    bus.BranchTaken = v[2];
    bus.MemReq      = v[1];
    bus.MemReady    = v[0];
  endtask

  function automatic logic [5:0] outs();
    return {bus.PCStall, bus.IFIDStall, bus.ControlMux, bus.IFIDFlush,
            bus.PipeFreeze, bus.MulDivBusy};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input logic [5:0] v, input logic [5:0] e, input string nm);
    drv(v);
    @(negedge Clk);
    chk(nm, 32'(outs()), 32'(e));
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    drv(6'b0);
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{6'b000000, 6'b000000};
    vt[1]  = '{6'b100000, 6'b111000};
    vt[2]  = '{6'b000100, 6'b000100};
    vt[3]  = '{6'b100100, 6'b111000};
    vt[4]  = '{6'b000111, 6'b000100};
    vt[5]  = '{6'b001000, 6'b000000};
    vt[6]  = '{6'b100110, 6'b110010};
    vt[7]  = '{6'b000111, 6'b000100};
    vt[8]  = '{6'b010010, 6'b110010};
    vt[9]  = '{6'b001001, 6'b000000};
    vt[10] = '{6'b010000, 6'b000000};
    vt[11] = '{6'b001000, 6'b111001};
    vt[12] = '{6'b001100, 6'b111001};
    vt[13] = '{6'b000100, 6'b000101};

    reset_dut();
    @(negedge Clk);
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_memerr", 32'(bus.MemError), 32'h0);
    chk("rst_stallcnt", 32'(bus.StallCycles), 32'h0);
    chk("rst_flushcnt", 32'(bus.FlushCount), 32'h0);
    tick();

    for (int i = 0; i < 14; i++) begin
      step(vt[i].in, vt[i].exp, $sformatf("vec%0d", i));
      tick();
    end

    // single-cycle load-use hazard
    reset_dut();
    step(6'b100000, 6'b111000, "hz_on");
    tick();
    step(6'b000000, 6'b000000, "hz_off");
    chk("hz_stallcnt", 32'(bus.StallCycles), 32'd1);
    tick();

    // mul/div busy window blocks HI/LO reader for exactly MULDIV_LAT cycles
    reset_dut();
    step(6'b010000, 6'b000000, "md_start");
    tick();
    for (int k = 0; k < 4; k++) begin
      step(6'b001000, 6'b111001, $sformatf("md_busy%0d", k));
      tick();
    end
    step(6'b001000, 6'b000000, "md_done");
    tick();

    // memory wait with hazard and branch pending: freeze, then stall, then flush
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      step(6'b100110, 6'b110010, $sformatf("mw_frz%0d", k));
      tick();
    end
    step(6'b100111, 6'b111000, "mw_release");
    tick();
    step(6'b000100, 6'b000100, "mw_flush");
    chk("mw_stallcnt", 32'(bus.StallCycles), 32'd4);
    tick();
    step(6'b000000, 6'b000000, "mw_idle");
    chk("mw_flushcnt", 32'(bus.FlushCount), 32'd1);
    tick();

    // timeout into FAULT, then reset recovery
    reset_dut();
    for (int k = 0; k < 9; k++) begin
      step(6'b000010, 6'b110010, $sformatf("to_wait%0d", k));
      if (k == 8) chk("to_memerr_pre", 32'(bus.MemError), 32'h0);
      tick();
    end
    step(6'b000000, 6'b110010, "fault_frz");
    chk("fault_memerr", 32'(bus.MemError), 32'h1);
    tick();
    step(6'b100100, 6'b110010, "fault_hold");
    chk("fault_memerr2", 32'(bus.MemError), 32'h1);
    tick();
    Rst = 1'b1;
    drv(6'b0);
    tick();
    Rst = 1'b0;
    step(6'b000000, 6'b000000, "fault_rst_outs");
    chk("fault_rst_memerr", 32'(bus.MemError), 32'h0);
    chk("fault_rst_stallcnt", 32'(bus.StallCycles), 32'h0);
    tick();
    step(6'b000100, 6'b000100, "fault_rst_run");
    tick();

    // reset mid-busy and mid-wait
    reset_dut();
    step(6'b010000, 6'b000000, "mr_start");
    tick();
    step(6'b000010, 6'b110011, "mr_wait0");
    tick();
    step(6'b000010, 6'b110011, "mr_wait1");
    tick();
    Rst = 1'b1;
    drv(6'b000010);
    tick();
    Rst = 1'b0;
    step(6'b001000, 6'b000000, "mr_after_rst");
    chk("mr_memerr", 32'(bus.MemError), 32'h0);
    tick();
    step(6'b000010, 6'b110010, "mr_live_freeze");
    tick();
    step(6'b000011, 6'b000000, "mr_live_ready");
    tick();

    // flush counter saturation
    reset_dut();
    drv(6'b000100);
    repeat (70000) tick();
    @(negedge Clk);
    chk("sat_flushcnt", 32'(bus.FlushCount), 32'hFFFF);
    chk("sat_stallcnt", 32'(bus.StallCycles), 32'h0);
    tick();
    drv(6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
